// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM state type,
// instruction width and sequential PC increment.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selector: an aligned redirect target wins over sequential PC+PC_STEP.
module pc_next_sel
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [DATA_W-1:0] i_pc,
    input  logic              i_br_valid,
    input  logic [DATA_W-1:0] i_br_target,
    output logic [DATA_W-1:0] o_next_pc
);

    logic [DATA_W-1:0] w_step;
    logic [DATA_W-1:0] w_align_mask;
    logic [DATA_W-1:0] w_seq_pc;
    logic [DATA_W-1:0] w_br_pc;

    assign w_step       = DATA_W'(PC_STEP);
    // Clearing the low address bits forces a misaligned target onto a word boundary.
    assign w_align_mask = ~(w_step - DATA_W'(1));
    assign w_seq_pc     = i_pc + w_step;
    assign w_br_pc      = i_br_target & w_align_mask;

    always_comb begin
        o_next_pc = w_seq_pc;
        if (i_br_valid) begin
            o_next_pc = w_br_pc;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: issues one memory request at a time, delivers
// returned words with their PC, and handles redirects and downstream stalls.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int unsigned        DATA_W   = 64,
    parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_stall,
    input  logic              i_br_valid,
    input  logic [DATA_W-1:0] i_br_target,
    output logic              o_i_valid,
    output logic [DATA_W-1:0] o_i_addr,
    input  logic              i_i_ready,
    input  logic              i_i_rvalid,
    input  logic [INST_W-1:0] i_i_rdata,
    output logic              o_inst_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [DATA_W-1:0] o_inst_pc,
    output logic              o_busy
);

    fetch_state_t      r_state;
    logic [DATA_W-1:0] r_pc;
    logic              r_squash;
    logic [INST_W-1:0] r_inst;
    logic [DATA_W-1:0] r_inst_pc;
    logic              r_inst_valid;
    logic [DATA_W-1:0] w_next_pc;

    pc_next_sel #(
        .DATA_W (DATA_W)
    ) u_pc_next_sel (
        .i_pc        (r_pc),
        .i_br_valid  (i_br_valid),
        .i_br_target (i_br_target),
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_squash     <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc     <= RESET_PC;
                        r_squash <= 1'b0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (i_br_valid) begin
                        r_pc <= w_next_pc;
                    end
                    // A redirect on the accepting cycle leaves a stale request in flight.
                    if (i_i_ready) begin
                        r_squash <= i_br_valid;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_i_rvalid) begin
                        r_squash <= 1'b0;
                        r_state  <= i_stall ? S_HOLD : S_FETCH;
                        if (i_br_valid) begin
                            r_pc <= w_next_pc;
                        end else if (!r_squash) begin
                            r_inst       <= i_i_rdata;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= w_next_pc;
                        end
                    end else if (i_br_valid) begin
                        r_squash <= 1'b1;
                        r_pc     <= w_next_pc;
                    end
                end
                S_HOLD: begin
                    if (i_br_valid) begin
                        r_pc <= w_next_pc;
                    end
                    if (!i_stall) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_i_valid    = (r_state == S_FETCH);
    assign o_i_addr     = r_pc;
    assign o_inst_valid = r_inst_valid;
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_pc_fetch_ctrl;

    localparam logic [63:0] MAIN_RESET_PC = 64'h0;
    localparam logic [63:0] WRAP_RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, stall, br, ready, rvalid;
    logic [63:0] tgt;
    logic [31:0] rdata;
    logic        o_ival, o_instv, o_busy;
    logic [63:0] o_addr, o_ipc;
    logic [31:0] o_inst;

    logic        w_start, w_ready, w_rvalid;
    logic        w_ival, w_instv, w_busy;
    logic [63:0] w_addr, w_ipc;
    logic [31:0] w_inst;

    pc_fetch_ctrl #(.DATA_W(64), .RESET_PC(MAIN_RESET_PC)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stall(stall),
        .i_br_valid(br), .i_br_target(tgt),
        .o_i_valid(o_ival), .o_i_addr(o_addr), .i_i_ready(ready),
        .i_i_rvalid(rvalid), .i_i_rdata(rdata),
        .o_inst_valid(o_instv), .o_inst(o_inst), .o_inst_pc(o_ipc), .o_busy(o_busy)
    );

    pc_fetch_ctrl #(.DATA_W(64), .RESET_PC(WRAP_RESET_PC)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(w_start), .i_stall(1'b0),
        .i_br_valid(1'b0), .i_br_target(64'h0),
        .o_i_valid(w_ival), .o_i_addr(w_addr), .i_i_ready(w_ready),
        .i_i_rvalid(w_rvalid), .i_i_rdata(32'hCAFE_0001),
        .o_inst_valid(w_instv), .o_inst(w_inst), .o_inst_pc(w_ipc), .o_busy(w_busy)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: running / request outstanding / response to drop / held by stall
    bit          m_run, m_out, m_drop, m_held, m_iv;
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_inst;
    bit          auto_rsp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic model_reset();
        m_run = 0; m_out = 0; m_drop = 0; m_held = 0; m_iv = 0;
        m_pc = MAIN_RESET_PC; m_ipc = '0; m_inst = '0;
    endtask

    task automatic model_advance();
        logic [63:0] t_al;
        t_al = tgt & ~64'h3;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_iv = 0;
        if (!m_run) begin
            if (start) begin
                m_run = 1; m_pc = MAIN_RESET_PC; m_out = 0; m_held = 0; m_drop = 0;
            end
        end else if (m_held) begin
            if (br) m_pc = t_al;
            if (!stall) m_held = 0;
        end else if (m_out) begin
            if (rvalid) begin
                if (!m_drop && !br) begin
                    m_inst = rdata; m_ipc = m_pc; m_iv = 1; m_pc = m_pc + 64'd4;
                end
                if (br) m_pc = t_al;
                m_out = 0; m_drop = 0; m_held = stall;
            end else if (br) begin
                m_drop = 1; m_pc = t_al;
            end
        end else begin
            if (ready) m_out = 1;
            if (br) begin
                m_pc = t_al;
                if (ready) m_drop = 1;
            end
        end
    endtask

    task automatic compare_all();
        chk1("m_i_valid", o_ival, m_run && !m_out && !m_held);
        chk ("m_i_addr", o_addr, m_pc);
        chk1("m_busy", o_busy, m_run);
        chk1("m_inst_valid", o_instv, m_iv);
        chk ("m_inst", 64'(o_inst), 64'(m_inst));
        chk ("m_inst_pc", o_ipc, m_ipc);
    endtask

    task automatic tick();
        if (auto_rsp) rvalid = m_out;
        model_advance();
        @(negedge clk);
        compare_all();
    endtask

    task automatic restart();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] addr_q[$];
        logic [63:0] ipc_q[$];
        int holds;
        int pulses;

        rst_n = 0; start = 0; stall = 0; br = 0; ready = 0; rvalid = 0;
        tgt = '0; rdata = '0; w_start = 0; w_ready = 0; w_rvalid = 0;
        @(negedge clk);
        model_reset();
        compare_all();
        chk1("rst_busy", o_busy, 1'b0);
        chk ("rst_addr", o_addr, 64'h0);
        chk1("rst_inst_valid", o_instv, 1'b0);
        chk ("wrap_rst_addr", w_addr, WRAP_RESET_PC);
        chk1("wrap_rst_busy", w_busy, 1'b0);
        rst_n = 1;

        // Always-ready memory, response one cycle after acceptance
        start = 1; ready = 1; auto_rsp = 1;
        tick();
        start = 0;
        for (int i = 0; i < 8; i++) begin
            if (o_ival) addr_q.push_back(o_addr);
            if (o_instv) ipc_q.push_back(o_ipc);
            tick();
        end
        auto_rsp = 0; rvalid = 0; ready = 0;
        chk("seq_addr_count_ge4", 64'(addr_q.size() >= 4), 64'd1);
        chk("seq_pc_count_ge3", 64'(ipc_q.size() >= 3), 64'd1);
        if (addr_q.size() >= 4 && ipc_q.size() >= 3) begin
            chk("seq_addr0", addr_q[0], 64'd0);
            chk("seq_addr1", addr_q[1], 64'd4);
            chk("seq_addr2", addr_q[2], 64'd8);
            chk("seq_addr3", addr_q[3], 64'd12);
            chk("seq_pc0", ipc_q[0], 64'd0);
            chk("seq_pc1", ipc_q[1], 64'd4);
            chk("seq_pc2", ipc_q[2], 64'd8);
        end

        // Memory not ready for 3 cycles
        restart();
        ready = 0;
        chk1("nrdy_valid0", o_ival, 1'b1);
        chk ("nrdy_addr0", o_addr, 64'h0);
        for (int i = 1; i < 3; i++) begin
            tick();
            chk1("nrdy_valid", o_ival, 1'b1);
            chk ("nrdy_addr", o_addr, 64'h0);
        end
        ready = 1;
        tick();
        ready = 0;

        // Redirect to misaligned target while waiting
        br = 1; tgt = 64'h103;
        tick();
        br = 0;
        rvalid = 1;
        tick();
        rvalid = 0;
        chk1("squash_no_inst", o_instv, 1'b0);
        chk1("squash_refetch_valid", o_ival, 1'b1);
        chk ("squash_refetch_addr", o_addr, 64'h100);

        // Stall at response time for 4 cycles
        ready = 1;
        tick();
        ready = 0; rvalid = 1; stall = 1; rdata = 32'h1234_5678;
        tick();
        rvalid = 0;
        chk1("stall_pulse", o_instv, 1'b1);
        chk ("stall_inst_pc", o_ipc, 64'h100);
        chk ("stall_inst", 64'(o_inst), 64'h1234_5678);
        holds = (!o_ival && o_busy) ? 1 : 0;
        pulses = o_instv ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (!o_ival && o_busy) holds++;
            if (o_instv) pulses++;
        end
        chk("stall_hold_cycles", 64'(holds), 64'd4);
        chk("stall_pulse_count", 64'(pulses), 64'd1);
        stall = 0;
        tick();
        chk1("stall_resume_valid", o_ival, 1'b1);
        chk ("stall_resume_addr", o_addr, 64'h104);

        // Reset during WAIT, then a late response
        ready = 1;
        tick();
        ready = 0;
        rst_n = 0;
        #1;
        chk1("rstwait_busy", o_busy, 1'b0);
        chk1("rstwait_inst_valid", o_instv, 1'b0);
        model_reset();
        rst_n = 1;
        rvalid = 1;
        tick();
        rvalid = 0;
        chk1("late_rvalid_inst_valid", o_instv, 1'b0);
        chk1("late_rvalid_busy", o_busy, 1'b0);

        // Wrap of PC+4 at the top of the address space
        w_start = 1;
        tick();
        w_start = 0;
        chk ("wrap_addr0", w_addr, WRAP_RESET_PC);
        chk1("wrap_valid0", w_ival, 1'b1);
        w_ready = 1;
        tick();
        w_ready = 0; w_rvalid = 1;
        tick();
        w_rvalid = 0;
        chk ("wrap_addr1", w_addr, 64'h0);
        chk1("wrap_valid1", w_ival, 1'b1);
        chk1("wrap_inst_valid", w_instv, 1'b1);
        chk ("wrap_inst_pc", w_ipc, WRAP_RESET_PC);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom_range(0, 399) != 0);
            start  = m_run ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            stall  = ($urandom_range(0, 2) == 0);
            br     = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 2))
                0:       tgt = {$urandom, $urandom};
                1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: tgt = 64'($urandom_range(0, 255));
            endcase
            ready  = ($urandom_range(0, 1) == 1);
            rvalid = (m_out || !m_run) ? ($urandom_range(0, 2) == 0) : 1'b0;
            rdata  = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
